// File: rtl/param_sync_ram.sv
// Simple dual-port synchronous RAM with a clear-after-reset sweep,
// write-first collision bypass, and out-of-range error flags.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_CLEAR | sweeping zeros into every word, requests are ignored
// S_IDLE  | ready; one write and one read can be accepted per cycle
module param_sync_ram #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 2**ADDR_W,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              werr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              rerr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_ptr;
    logic              clr_we;
    logic              clr_last;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_acc, rd_acc;
    logic              w_oor, r_oor;
    logic              collide;

    logic              v1, e1;
    logic [DATA_W-1:0] d1;

    // Addresses are unsigned; a full-depth RAM can never flag an error.
    assign w_oor    = ({1'b0, waddr} >= DEPTH_W);
    assign r_oor    = ({1'b0, raddr} >= DEPTH_W);
    assign clr_last = (clr_ptr == ADDR_W'(DEPTH - 1));

    // ready is registered and tracks the state, so it gates acceptance.
    assign wr_acc  = ready & wr_en;
    assign rd_acc  = ready & rd_en;
    assign collide = wr_acc & ~w_oor & (waddr == raddr);

    // Next-state and clear-write strobe.
    always_comb begin
        state_nxt = state;
        clr_we    = 1'b0;
        case (state)
            S_CLEAR: begin
                clr_we = 1'b1;
                if (clr_last) state_nxt = S_IDLE;
            end
            S_IDLE:  state_nxt = S_IDLE;
            default: state_nxt = S_CLEAR;
        endcase
    end

    // State register with ready registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEAR;
            ready <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= (state_nxt == S_IDLE);
        end
    end

    // Clear sweep pointer; restarts at zero on every reset.
    always_ff @(posedge clk) begin
        if (rst)         clr_ptr <= '0;
        else if (clr_we) clr_ptr <= clr_ptr + 1'b1;
    end

    // Storage array; deliberately left untouched while rst is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we)
                mem[clr_ptr[IDX_W-1:0]] <= '0;
            else if (wr_acc && !w_oor)
                mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    // Write error pulse, one cycle after the offending write.
    always_ff @(posedge clk) begin
        if (rst) werr <= 1'b0;
        else     werr <= wr_acc & w_oor;
    end

    // First read stage: data register holds its value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            e1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= rd_acc;
            e1 <= rd_acc & r_oor;
            if (rd_acc) begin
                if (r_oor)        d1 <= '0;
                else if (collide) d1 <= wdata;
                else              d1 <= mem[raddr[IDX_W-1:0]];
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic              v2, e2;
            logic [DATA_W-1:0] d2;

            // Extra output register stage for the two-cycle latency option.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v2 <= 1'b0;
                    e2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    e2 <= e1;
                    if (v1) d2 <= d1;
                end
            end

            assign rvalid = v2;
            assign rerr   = e2;
            assign rdata  = d2;
        end else begin : g_lat1
            assign rvalid = v1;
            assign rerr   = e1;
            assign rdata  = d1;
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_ram.sv
// Bench for param_sync_ram: two instances (read latency 1 and 2) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_param_sync_ram;

    localparam int DEP = 200;

    logic       clk = 1'b0;
    logic       rst, wr_en, rd_en;
    logic [7:0] waddr, wdata, raddr;
    logic       ready1, werr1, rvalid1, rerr1;
    logic [7:0] rdata1;
    logic       ready2, werr2, rvalid2, rerr2;
    logic [7:0] rdata2;

    always #5 clk = ~clk;

    param_sync_ram #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEP), .RD_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .ready(ready1),
        .wr_en(wr_en), .waddr(waddr), .wdata(wdata), .werr(werr1),
        .rd_en(rd_en), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .rerr(rerr1)
    );

    param_sync_ram #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEP), .RD_LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst), .ready(ready2),
        .wr_en(wr_en), .waddr(waddr), .wdata(wdata), .werr(werr2),
        .rd_en(rd_en), .raddr(raddr), .rdata(rdata2), .rvalid(rvalid2), .rerr(rerr2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory as a plain array, read results as
    // "visible after this edge" (latency 1) or "after the next edge" (latency 2).
    int  m_mem [256];
    bit  m_ready, m_werr, chk_en;
    int  m_clr;
    bit  m_v1, m_e1, m_v2, m_e2, m_pv, m_pe, m_nv, m_ne;
    int  m_d1, m_d2, m_pd, m_nd;

    initial chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_ready = 0; m_clr = 0; m_werr = 0;
            m_v1 = 0; m_e1 = 0; m_d1 = 0;
            m_v2 = 0; m_e2 = 0; m_d2 = 0;
            m_pv = 0; m_pe = 0; m_pd = 0;
            chk_en = 1;
        end else begin
            m_nv = 0; m_ne = 0; m_nd = 0;
            if (!m_ready) begin
                m_werr = 0;
                m_clr++;
                if (m_clr == DEP) begin
                    m_ready = 1;
                    foreach (m_mem[i]) m_mem[i] = 0;
                end
            end else begin
                m_werr = wr_en && (int'(waddr) >= DEP);
                if (wr_en && int'(waddr) < DEP) m_mem[waddr] = int'(wdata);
                if (rd_en) begin
                    m_nv = 1;
                    m_ne = (int'(raddr) >= DEP);
                    m_nd = m_ne ? 0 : m_mem[raddr];
                end
            end
            m_v1 = m_nv; m_e1 = m_ne;
            if (m_nv) m_d1 = m_nd;
            m_v2 = m_pv; m_e2 = m_pe;
            if (m_pv) m_d2 = m_pd;
            m_pv = m_nv; m_pe = m_ne; m_pd = m_nd;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready1", ready1, m_ready);
            check("ready2", ready2, m_ready);
            check("werr1", werr1, m_werr);
            check("werr2", werr2, m_werr);
            check("rvalid1", rvalid1, m_v1);
            check("rerr1", rerr1, m_e1);
            check("rdata1", rdata1, m_d1);
            check("rvalid2", rvalid2, m_v2);
            check("rerr2", rerr2, m_e2);
            check("rdata2", rdata2, m_d2);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit we, input int wa, input int wd, input bit re, input int ra);
        wr_en = we;
        waddr = wa[7:0];
        wdata = wd[7:0];
        rd_en = re;
        raddr = ra[7:0];
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0);
    endtask

    int cnt;

    initial begin
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;

        // Reset in the middle of the sweep restarts it.
        repeat (30) step();
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Count clear cycles; requests during the sweep must be ignored.
        cnt = 0;
        while (!ready1 && cnt < 400) begin
            if (cnt >= 50 && cnt < 53) drive(1, 4, 'h55, 1, 4);
            else                       idle();
            step();
            cnt++;
        end
        idle();
        check("clear_len", cnt, 200);
        check("model_ready", m_ready, 1);

        drive(0, 0, 0, 1, 2);
        step();
        idle();
        check("rd2_valid", rvalid1, 1);
        check("rd2_data", rdata1, 0);
        check("rd2_err", rerr1, 0);

        drive(0, 0, 0, 1, 4);
        step();
        idle();
        check("rd4_ignored_wr", rdata1, 0);

        // Basic write then back-to-back reads.
        drive(1, 5, 29, 0, 0); step();
        drive(1, 3, 12, 0, 0); step();
        drive(0, 0, 0, 1, 5);  step();
        check("rd5_valid", rvalid1, 1);
        check("rd5_data", rdata1, 29);
        check("model_rd5", m_d1, 29);
        drive(0, 0, 0, 1, 3);  step();
        check("rd3_valid", rvalid1, 1);
        check("rd3_data", rdata1, 12);
        idle();                step();
        check("rd_done_valid", rvalid1, 0);
        check("rdata_hold", rdata1, 12);

        // Write-first collision.
        drive(1, 7, 'hA5, 1, 7); step();
        check("coll_data", rdata1, 'hA5);
        drive(0, 0, 0, 1, 7);    step();
        check("coll_after", rdata1, 'hA5);
        idle();                  step();

        // Out of range write and read.
        drive(1, 210, 'h11, 0, 0); step();
        check("werr_pulse", werr1, 1);
        idle();                    step();
        check("werr_clear", werr1, 0);
        drive(0, 0, 0, 1, 210);    step();
        check("oor_valid", rvalid1, 1);
        check("oor_data", rdata1, 0);
        check("oor_err", rerr1, 1);
        idle();                    step();

        // Two-cycle latency instance.
        drive(1, 1, 'h10, 0, 0); step();
        drive(1, 2, 'h20, 0, 0); step();
        drive(1, 3, 'h30, 0, 0); step();
        drive(0, 0, 0, 1, 1);    step();
        check("l2_first_wait", rvalid2, 0);
        drive(0, 0, 0, 1, 2);    step();
        check("l2_v0", rvalid2, 1);
        check("l2_d0", rdata2, 'h10);
        drive(0, 0, 0, 1, 3);    step();
        check("l2_v1", rvalid2, 1);
        check("l2_d1", rdata2, 'h20);
        idle();                  step();
        check("l2_v2", rvalid2, 1);
        check("l2_d2", rdata2, 'h30);
        step();
        check("l2_end", rvalid2, 0);

        // Reset with a read still in flight discards it.
        drive(0, 0, 0, 1, 1);    step();
        drive(0, 0, 0, 1, 2);    step();
        check("l2r_v0", rvalid2, 1);
        check("l2r_d0", rdata2, 'h10);
        idle();
        rst = 1'b1;              step();
        check("l2r_flush", rvalid2, 0);
        rst = 1'b0;
        cnt = 0;
        while (!ready1 && cnt < 400) begin
            step();
            cnt++;
        end
        check("clear_len2", cnt, 200);

        // Randomised traffic, biased to a small window to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            int wa, ra;
            wa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
            ra = ($urandom_range(0, 3) == 0) ? wa :
                 (($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15));
            drive($urandom_range(0, 1), wa, $urandom_range(0, 255), $urandom_range(0, 1), ra);
            rst = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/param_sync_ram.md
Name: param_sync_ram

Overview:
- Parametrised successor to the team's 8-bit RWn RAM.
- Simple dual-port synchronous RAM: one write port and one read port per cycle.
- Configurable width, depth and read latency; registered read-valid handshake.
- Built-in clear-after-reset sweep, write-first collision bypass and out-of-range error flags.
- Sits behind the testbench interface as the DUT for read/write task sequences.

Parameters:
- DATA_W, 8, data bus width in bits (1..64).
- ADDR_W, 8, address bus width in bits (1..16).
- DEPTH, 2**ADDR_W, number of implemented words (1..2**ADDR_W); addresses >= DEPTH are out of range.
- RD_LATENCY, 1, clock edges from read acceptance to rvalid (1 or 2).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- ready  output  1  high when requests are accepted (IDLE state).
- wr_en  input  1  write request, sampled at posedge when ready=1.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- werr  output  1  one-cycle pulse: accepted write was out of range.
- rd_en  input  1  read request, sampled at posedge when ready=1.
- raddr  input  ADDR_W  read address.
- rdata  output  DATA_W  read data, valid when rvalid=1.
- rvalid  output  1  read data valid strobe.
- rerr  output  1  qualifies rdata when rvalid=1: read was out of range.

Behaviour:
- Reset (rst=1 at posedge): state<=CLEAR, clr_ptr<=0, ready=0, rvalid=0, rdata=0, rerr=0, werr=0, read pipeline flushed. Memory contents are not touched during rst itself.
- FSM, two states:
  - CLEAR: writes 0 to mem[clr_ptr], increments clr_ptr each cycle; when clr_ptr==DEPTH-1, next state is IDLE. Duration is exactly DEPTH cycles after rst deasserts.
  - IDLE: ready=1, stays until rst.
- ready is a registered output equal to (state==IDLE).
- rst asserted mid-CLEAR restarts the sweep at address 0.
- wr_en/rd_en with ready=0 are ignored: no memory update, no rvalid, no error pulse.
- Write: accepted at edge N with waddr<DEPTH -> mem[waddr]<=wdata at edge N. With waddr>=DEPTH: no update, werr=1 for the cycle after edge N only.
- Read, accepted at edge N:
  - rvalid=1 for one cycle after edge N+RD_LATENCY-1, i.e. visible in the cycle following the data edge.
  - RD_LATENCY=1: data registered at edge N. RD_LATENCY=2: one extra output register stage.
  - Back-to-back reads every cycle are supported and return in order; full throughput.
- rdata holds its last value while rvalid=0. rerr is 0 whenever rvalid=0.
- Out-of-range read (raddr>=DEPTH): rdata=0, rerr=1 with rvalid.
- Collision (accepted wr_en and rd_en in the same cycle, waddr==raddr, in range): write-first, so rdata returns the new wdata.
- Read of an address written at any earlier edge returns the written value.
- rst during an outstanding read: rvalid=0 from the next cycle; the pending result is discarded.
- Address width rule: waddr/raddr are compared unsigned against DEPTH. When DEPTH==2**ADDR_W, werr/rerr never assert.

Test Plan:
- Test configuration: DATA_W=8, ADDR_W=8, DEPTH=200, RD_LATENCY=1 unless stated.
- Clear sweep: rst high 2 cycles then low -> ready=0 for exactly 200 cycles, then 1; then read addr 2 -> rvalid next cycle, rdata=0, rerr=0.
- Basic write/read: write 5<=29, write 3<=12, read 5, read 3 back-to-back -> rvalid two consecutive cycles with rdata 29 then 12.
- Collision: same cycle write 7<=0xA5 and read 7 (mem[7]=0) -> rdata=0xA5; a following read of 7 also returns 0xA5.
- Out of range: write 210<=0x11 -> werr one-cycle pulse, no memory change anywhere; read 210 -> rvalid=1, rdata=0, rerr=1.
- Ignored during clear: during CLEAR drive wr_en with 4<=0x55 and rd_en on 4 -> no rvalid, no werr; after ready, read 4 -> 0.
- RD_LATENCY=2: reads of 1, 2, 3 on consecutive cycles (preloaded 0x10, 0x20, 0x30) -> rvalid high 3 consecutive cycles starting 2 edges after the first request, data 0x10, 0x20, 0x30. Repeat with rst asserted after the second read -> rvalid=0 from the next cycle and no further data returned.
